// File: rtl/note_lane_judge_if.sv
// Port bundle between the game core and note_lane_judge.
// The combo output exists only when NOTE_LANE_JUDGE_COMBO_EN is defined.
interface note_lane_judge_if #(
  parameter int LANES   = 5,
  parameter int Y_W     = 10,
  parameter int SCORE_W = 13,
  parameter int MISS_W  = 4
);
  logic                   enable;
  logic                   tick;
  logic [LANES-1:0]       spawn;
  logic [LANES-1:0]       boton;
  logic [LANES-1:0]       note_valid;
  logic [LANES*Y_W-1:0]   note_y;
  logic [LANES-1:0]       hit_pulse;
  logic [LANES-1:0]       miss_pulse;
  logic [SCORE_W-1:0]     puntuacion;
  logic [MISS_W-1:0]      misses;
  logic                   perdio;
`ifdef NOTE_LANE_JUDGE_COMBO_EN
  logic [7:0]             combo;

  modport master (
    output enable, tick, spawn, boton,
    input  note_valid, note_y, hit_pulse, miss_pulse, puntuacion, misses, perdio, combo
  );
  modport slave (
    input  enable, tick, spawn, boton,
    output note_valid, note_y, hit_pulse, miss_pulse, puntuacion, misses, perdio, combo
  );
`else
  modport master (
    output enable, tick, spawn, boton,
    input  note_valid, note_y, hit_pulse, miss_pulse, puntuacion, misses, perdio
  );
  modport slave (
    input  enable, tick, spawn, boton,
    output note_valid, note_y, hit_pulse, miss_pulse, puntuacion, misses, perdio
  );
`endif
endinterface

// File: rtl/note_lane_judge.sv
// N-lane falling-note engine and hit judge with saturating score/miss counters and sticky loss flag.
// Define NOTE_LANE_JUDGE_COMBO_EN to add the combo counter and score multiplier.
module note_lane_judge #(
  parameter int LANES      = 5,
  parameter int Y_W        = 10,
  parameter int HIT_Y      = 384,
  parameter int WINDOW     = 16,
  parameter int STEP       = 4,
  parameter int SCORE_W    = 13,
  parameter int MISS_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  note_lane_judge_if.slave  bus
);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int unsigned SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;
  localparam int unsigned MISS_MAX  = MISS_LIMIT;
  localparam int unsigned Y_HI      = HIT_Y + WINDOW;
  localparam int unsigned Y_LO_ADJ  = HIT_Y;

  function automatic logic [CNT_W-1:0] count_ones(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic in_window(input logic [Y_W-1:0] y);
    return ((32'(y) + 32'(WINDOW)) >= Y_LO_ADJ) && (32'(y) <= Y_HI);
  endfunction

  logic [LANES-1:0]     prev_r;
  logic [LANES-1:0]     valid_r, valid_n;
  logic [LANES*Y_W-1:0] y_r, y_n;
  logic [LANES-1:0]     hit_s, miss_s, press_s;
  logic [LANES-1:0]     hit_pulse_r, miss_pulse_r;
  logic [SCORE_W-1:0]   score_r, score_n;
  logic [MISS_W-1:0]    misses_r, misses_n;
  logic                 perdio_r, perdio_n;
  logic                 run_s;
  logic [CNT_W-1:0]     hit_cnt_s, miss_cnt_s;
  logic [2:0]           mult_s;
  logic [31:0]          score_sum_s, miss_sum_s;
`ifdef NOTE_LANE_JUDGE_COMBO_EN
  logic [7:0]           combo_r, combo_n;
  logic [8:0]           combo_sum_s;
`endif

  assign run_s   = bus.enable & ~perdio_r;
  assign press_s = bus.boton & ~prev_r;

  // Per-lane judge: hit beats tick-advance, which beats spawn.
  always_comb begin
    valid_n = valid_r;
    y_n     = y_r;
    hit_s   = '0;
    miss_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (run_s && valid_r[i] && press_s[i] && in_window(y_r[i*Y_W +: Y_W])) begin
        valid_n[i] = 1'b0;
        hit_s[i]   = 1'b1;
      end else if (run_s && valid_r[i] && bus.tick) begin
        y_n[i*Y_W +: Y_W] = y_r[i*Y_W +: Y_W] + Y_W'(STEP);
        if (32'(y_n[i*Y_W +: Y_W]) > Y_HI) begin
          valid_n[i] = 1'b0;
          miss_s[i]  = 1'b1;
        end else begin
          valid_n[i] = 1'b1;
        end
      end else if (run_s && !valid_r[i] && bus.spawn[i]) begin
        valid_n[i]        = 1'b1;
        y_n[i*Y_W +: Y_W] = '0;
      end else begin
        valid_n[i] = valid_r[i];
      end
    end
  end

  // Score, miss and combo accounting from this cycle's hit/miss counts.
  always_comb begin
    hit_cnt_s  = count_ones(hit_s);
    miss_cnt_s = count_ones(miss_s);
`ifdef NOTE_LANE_JUDGE_COMBO_EN
    if (combo_r >= 8'd12) begin
      mult_s = 3'd4;
    end else begin
      mult_s = 3'd1 + {1'b0, combo_r[3:2]};
    end
    combo_sum_s = {1'b0, combo_r} + 9'(hit_cnt_s);
    if (miss_cnt_s != '0) begin
      combo_n = 8'd0;
    end else if (combo_sum_s > 9'd255) begin
      combo_n = 8'd255;
    end else begin
      combo_n = combo_sum_s[7:0];
    end
`else
    mult_s = 3'd1;
`endif
    score_sum_s = 32'(score_r) + (32'(hit_cnt_s) * 32'(mult_s));
    if (score_sum_s > SCORE_MAX) begin
      score_n = SCORE_W'(SCORE_MAX);
    end else begin
      score_n = SCORE_W'(score_sum_s);
    end
    miss_sum_s = 32'(misses_r) + 32'(miss_cnt_s);
    if (miss_sum_s >= MISS_MAX) begin
      misses_n = MISS_W'(MISS_MAX);
      perdio_n = 1'b1;
    end else begin
      misses_n = MISS_W'(miss_sum_s);
      perdio_n = perdio_r;
    end
  end

  // State and output registers; reset clears everything including button history.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r       <= '0;
      valid_r      <= '0;
      y_r          <= '0;
      hit_pulse_r  <= '0;
      miss_pulse_r <= '0;
      score_r      <= '0;
      misses_r     <= '0;
      perdio_r     <= 1'b0;
`ifdef NOTE_LANE_JUDGE_COMBO_EN
      combo_r      <= 8'd0;
`endif
    end else begin
      prev_r       <= bus.boton;
      valid_r      <= valid_n;
      y_r          <= y_n;
      hit_pulse_r  <= hit_s;
      miss_pulse_r <= miss_s;
      score_r      <= score_n;
      misses_r     <= misses_n;
      perdio_r     <= perdio_n;
`ifdef NOTE_LANE_JUDGE_COMBO_EN
      combo_r      <= combo_n;
`endif
    end
  end

  assign bus.note_valid = valid_r;
  assign bus.note_y     = y_r;
  assign bus.hit_pulse  = hit_pulse_r;
  assign bus.miss_pulse = miss_pulse_r;
  assign bus.puntuacion = score_r;
  assign bus.misses     = misses_r;
  assign bus.perdio     = perdio_r;
`ifdef NOTE_LANE_JUDGE_COMBO_EN
  assign bus.combo      = combo_r;
`endif
endmodule
